// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer
// Buffers packed ALSU commands in a small FIFO and replays each one onto the
// ALSU pins for (repeat+1) consecutive cycles. Commands are issued back to
// back with no bubble. Invalid opcodes (110/111 with no bypass) are flagged
// with a one-cycle pulse and counted with saturation.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   cmd_valid/ready   command handshake, cmd_data packed as
//                     {repeat, direction, bypass_B, bypass_A, red_op_B,
//                      red_op_A, serial_in, cin, opcode, B, A}
//   flush             synchronous abort of active command and FIFO clear
//   A..direction      registered ALSU operand/control pins
//   issue_valid/last  pins carry an active command / final repeat cycle
//   busy, fifo_count  occupancy status
//   err_invalid       pulse when an invalid command is loaded
//   invalid_count     saturating invalid-command count
//
// state | meaning
// IDLE  | no active command, pins 0
// ISSUE | pins carry a command, rem cycles left after this one

module alsu_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int REPEAT_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [16+REPEAT_W-1:0]    cmd_data,
    input  logic                      flush,
    output logic [2:0]                A,
    output logic [2:0]                B,
    output logic [2:0]                opcode,
    output logic                      cin,
    output logic                      serial_in,
    output logic                      red_op_A,
    output logic                      red_op_B,
    output logic                      bypass_A,
    output logic                      bypass_B,
    output logic                      direction,
    output logic                      issue_valid,
    output logic                      issue_last,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      err_invalid,
    output logic [CNT_W-1:0]          invalid_count
);

    localparam int CW = 16 + REPEAT_W;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [REPEAT_W-1:0]   rem_q, rem_d;
    logic [15:0]           pins_q, pins_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      inv_cnt_q, inv_cnt_d;

    logic                  push;
    logic                  pop;
    logic [CW-1:0]         head;
    logic                  head_invalid;

    assign cmd_ready = (count_q != FULL_CNT) && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    // opcode 11x without either bypass has no defined arithmetic meaning
    assign head_invalid = (head[8:7] == 2'b11) && !head[13] && !head[14];
    // pop only once the active command has finished its last repeat
    assign pop = !flush && (count_q != '0) && ((state_q == IDLE) || (rem_q == '0));

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rem_d     = rem_q;
        pins_d    = pins_q;
        valid_d   = valid_q;
        last_d    = last_q;
        err_d     = 1'b0;
        inv_cnt_d = inv_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        case (state_q)
            IDLE: begin
                pins_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
            ISSUE: begin
                if (rem_q != '0) begin
                    rem_d  = rem_q - REPEAT_W'(1);
                    last_d = (rem_q == REPEAT_W'(1));
                end else if (!pop) begin
                    state_d = IDLE;
                    pins_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = ISSUE;
            pins_d   = head[15:0];
            rem_d    = head[CW-1:16];
            last_d   = (head[CW-1:16] == '0);
            valid_d  = 1'b1;
            if (head_invalid) begin
                err_d = 1'b1;
                if (inv_cnt_q != '1) begin
                    inv_cnt_d = inv_cnt_q + CNT_W'(1);
                end
            end
        end

        if (flush) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            rem_d    = '0;
            pins_d   = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            pins_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            inv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            pins_q    <= pins_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    // storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    assign A             = pins_q[2:0];
    assign B             = pins_q[5:3];
    assign opcode        = pins_q[8:6];
    assign cin           = pins_q[9];
    assign serial_in     = pins_q[10];
    assign red_op_A      = pins_q[11];
    assign red_op_B      = pins_q[12];
    assign bypass_A      = pins_q[13];
    assign bypass_B      = pins_q[14];
    assign direction     = pins_q[15];
    assign issue_valid   = valid_q;
    assign issue_last    = last_q;
    assign busy          = valid_q || (count_q != '0);
    assign fifo_count    = count_q;
    assign err_invalid   = err_q;
    assign invalid_count = inv_cnt_q;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
module tb_alsu_cmd_sequencer;

    localparam int DEPTH    = 4;
    localparam int REPEAT_W = 4;
    localparam int CNT_W    = 8;
    localparam int CW       = 16 + REPEAT_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_data;
    logic          flush;
    logic [2:0]    A, B, opcode;
    logic          cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic          issue_valid, issue_last, busy, err_invalid;
    logic [2:0]    fifo_count;
    logic [CNT_W-1:0] invalid_count;

    int n_chk = 0;
    int n_err = 0;

    // reference model: queue of pending commands, active command with cycles left
    logic [CW-1:0] mq[$];
    logic [CW-1:0] act;
    bit            active;
    int            left;
    bit            m_err;
    int            m_inv;

    always #5 clk = ~clk;

    alsu_cmd_sequencer #(.DEPTH(DEPTH), .REPEAT_W(REPEAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .flush(flush),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction),
        .issue_valid(issue_valid), .issue_last(issue_last), .busy(busy),
        .fifo_count(fifo_count), .err_invalid(err_invalid),
        .invalid_count(invalid_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_invalid(input logic [CW-1:0] c);
        return (c[8:6] == 3'b110 || c[8:6] == 3'b111) && !c[13] && !c[14];
    endfunction

    function automatic void model_reset();
        mq.delete();
        active = 0;
        left   = 0;
        m_err  = 0;
        m_inv  = 0;
        act    = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [CW-1:0] d, input bit f);
        bit acc;
        acc = v && (mq.size() < DEPTH) && !f;
        m_err = 0;
        if (f) begin
            mq.delete();
            active = 0;
        end else begin
            if (active && left > 1) begin
                left--;
            end else if (mq.size() > 0) begin
                act    = mq.pop_front();
                left   = int'(act[CW-1:16]) + 1;
                active = 1;
                if (is_invalid(act)) begin
                    m_err = 1;
                    if (m_inv < CNT_MAX) m_inv++;
                end
            end else begin
                active = 0;
            end
            if (acc) mq.push_back(d);
        end
    endfunction

    task automatic check_outs();
        logic [15:0] pins;
        pins = {direction, bypass_B, bypass_A, red_op_B, red_op_A, serial_in, cin, opcode, B, A};
        chk("pins", 32'(pins), active ? 32'(act[15:0]) : 32'd0);
        chk("issue_valid", 32'(issue_valid), 32'(active));
        chk("issue_last", 32'(issue_last), 32'(active && left == 1));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("busy", 32'(busy), 32'(active || mq.size() != 0));
        chk("err_invalid", 32'(err_invalid), 32'(m_err));
        chk("invalid_count", 32'(invalid_count), 32'(m_inv));
    endtask

    // called just after a falling edge; drives inputs, takes one rising edge
    task automatic step(input bit v, input logic [CW-1:0] d, input bit f);
        cmd_valid = v;
        cmd_data  = d;
        flush     = f;
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() < DEPTH) && !f));
        @(posedge clk);
        model_step(v, d, f);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_data = '0; flush = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outs();
    endtask

    logic [CW-1:0] burst [5];
    int idx;
    int vcount;

    initial begin
        rst = 1'b0; cmd_valid = 0; cmd_data = '0; flush = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single cycle ADD-style command: opcode 010, A=3, B=2, cin=1
        step(1, {4'd0, 7'b0000001, 3'b010, 3'd2, 3'd3}, 0);
        idle(3);

        // shift command held for repeat+1 cycles
        vcount = 0;
        step(1, {4'd5, 7'b1000010, 3'b100, 3'd5, 3'd1}, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0);
            if (issue_valid) vcount++;
        end
        chk("shift_cycles", 32'(vcount), 32'd6);

        // five back-to-back pushes, first one repeats 3 times
        burst[0] = {4'd3, 7'b0, 3'b000, 3'd1, 3'd2};
        burst[1] = {4'd0, 7'b0, 3'b001, 3'd3, 3'd4};
        burst[2] = {4'd1, 7'b0, 3'b011, 3'd5, 3'd6};
        burst[3] = {4'd2, 7'b0, 3'b101, 3'd7, 3'd0};
        burst[4] = {4'd0, 7'b0, 3'b010, 3'd1, 3'd1};
        idx = 0;
        vcount = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            bit acc;
            acc = mq.size() < DEPTH;
            step(1, burst[idx], 0);
            if (issue_valid) vcount++;
            if (acc) idx++;
        end
        chk("burst_pushed", 32'(idx), 32'd5);
        for (int i = 0; i < 20; i++) begin
            step(0, '0, 0);
            if (issue_valid) vcount++;
        end
        chk("burst_cycles", 32'(vcount), 32'd11);

        // invalid opcode without bypass, then 111 with bypass_A
        step(1, {4'd0, 7'b0000000, 3'b110, 3'd1, 3'd2}, 0);
        step(1, {4'd0, 7'b0010000, 3'b111, 3'd1, 3'd2}, 0);
        idle(4);
        chk("inv_after_pair", 32'(invalid_count), 32'd1);

        // flush during 3rd cycle of a repeat=7 command with two queued
        step(1, {4'd7, 7'b0, 3'b001, 3'd2, 3'd2}, 0);
        step(1, {4'd0, 7'b0, 3'b010, 3'd3, 3'd3}, 0);
        step(1, {4'd0, 7'b0, 3'b011, 3'd4, 3'd4}, 0);
        step(0, '0, 0);
        step(1, {4'd0, 7'b0, 3'b000, 3'd1, 3'd1}, 1);
        chk("flush_valid", 32'(issue_valid), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        idle(3);

        // asynchronous reset in the middle of an issue
        step(1, {4'd7, 7'b0, 3'b100, 3'd6, 3'd6}, 0);
        step(1, {4'd2, 7'b0, 3'b101, 3'd6, 3'd6}, 0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(issue_valid), 32'd0);
        chk("arst_pins", 32'({A, B, opcode, cin, direction}), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [CW-1:0] d;
            d = CW'($urandom);
            if ($urandom_range(0, 3) != 0) d[CW-1:16] = REPEAT_W'($urandom_range(0, 2));
            step($urandom_range(0, 1) == 1, d, $urandom_range(0, 24) == 0);
        end
        idle(40);

        // invalid counter saturation
        do_reset();
        for (int i = 0; i < 320; i++) step(1, {4'd0, 7'b0, 3'b110, 3'd0, 3'd0}, 0);
        idle(8);
        chk("inv_saturated", 32'(invalid_count), 32'(CNT_MAX));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
